branch_predictor_bht: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage pipeline, replacing the single-bit predict-and-correct path. It is a direct-mapped branch target buffer with saturating history counters. The fetch stage reads it combinationally every cycle. The memory stage writes it when a branch or jump resolves. It also produces the mispredict flush and correction PC for the PC mux, and keeps running branch and mispredict statistics.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/sat_counter.sv | 23 ++
 rtl/branch_predictor_bht.sv | 132 +++++++++++++
 tb/tb_branch_predictor_bht.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer.
// Counter encodings, PC increment and PC field extraction.
package bp_pkg;

    localparam int PC_INC = 4;

    // Weakly-taken: MSB set, all lower bits clear.
    function automatic logic [31:0] ctr_weak_taken(input int w);
        return 32'(1) << (w - 1);
    endfunction

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic logic [31:0] ctr_weak_not_taken(input int w);
        return (32'(1) << (w - 1)) - 32'(1);
    endfunction

    // Table index: pc[idx_w+1:2].
    function automatic logic [63:0] pc_index(
        input logic [63:0] pc,
        input int          idx_w
    );
        return (pc >> 2) & ((64'(1) << idx_w) - 64'(1));
    endfunction

    // Tag: everything above the index bits.
    function automatic logic [63:0] pc_tag(
        input logic [63:0] pc,
        input int          idx_w
    );
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-value logic.
// Purely combinational; state lives in the caller.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_up,
    output logic [CTR_W-1:0] o_ctr
);

    // Step toward the taken/not-taken rail, holding at either end.
    always_comb begin
        o_ctr = i_ctr;
        if (i_up) begin
            if (i_ctr != {CTR_W{1'b1}})
                o_ctr = i_ctr + CTR_W'(1);
        end else begin
            if (i_ctr != '0)
                o_ctr = i_ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB with saturating direction counters.
// Combinational lookup, registered update, mispredict + stats.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [PC_W-1:0]   correct_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_WT  =
        CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT =
        CTR_W'(ctr_weak_not_taken(CTR_W));
    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [PC_W-1:0]   target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    entry_t r_tbl [ENTRIES];

    logic [STAT_W-1:0] r_branches;
    logic [STAT_W-1:0] r_mispred;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    entry_t           w_if_ent;
    entry_t           w_up_ent;
    logic             w_up_hit;
    logic [CTR_W-1:0] w_ctr_next;
    logic             w_mis;

    assign w_if_idx = IDX_W'(pc_index(64'(if_pc), IDX_W));
    assign w_if_tag = TAG_W'(pc_tag(64'(if_pc), IDX_W));
    assign w_up_idx = IDX_W'(pc_index(64'(upd_pc), IDX_W));
    assign w_up_tag = TAG_W'(pc_tag(64'(upd_pc), IDX_W));
    assign w_if_ent = r_tbl[w_if_idx];
    assign w_up_ent = r_tbl[w_up_idx];
    assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

    // Fetch-side lookup; reads the pre-update table contents.
    always_comb begin
        pred_hit    = w_if_ent.valid && (w_if_ent.tag == w_if_tag);
        pred_taken  = pred_hit && w_if_ent.ctr[CTR_W-1];
        pred_target = pred_taken ? w_if_ent.target : if_pc + INC;
    end

    // Resolve-side mispredict detection and redirect PC.
    always_comb begin
        w_mis = (upd_taken != upd_pred_taken) ||
                (upd_taken && (upd_pred_target != upd_target));
        mispredict = upd_valid && w_mis;
        correct_pc = '0;
        if (upd_valid)
            correct_pc = upd_taken ? upd_target : upd_pc + INC;
    end

    sat_counter #(
        .CTR_W (CTR_W)
    ) u_ctr (
        .i_ctr (w_up_ent.ctr),
        .i_up  (upd_taken),
        .o_ctr (w_ctr_next)
    );

    // Table write: train on hit, allocate on taken miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl[i].valid  <= 1'b0;
                r_tbl[i].tag    <= '0;
                r_tbl[i].target <= '0;
                r_tbl[i].ctr    <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                r_tbl[w_up_idx].ctr <= w_ctr_next;
                if (upd_taken)
                    r_tbl[w_up_idx].target <= upd_target;
            end else if (upd_taken) begin
                r_tbl[w_up_idx].valid  <= 1'b1;
                r_tbl[w_up_idx].tag    <= w_up_tag;
                r_tbl[w_up_idx].target <= upd_target;
                r_tbl[w_up_idx].ctr    <= CTR_WT;
            end
        end
    end

    // Running branch and mispredict counts, wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branches <= '0;
            r_mispred  <= '0;
        end else begin
            if (upd_valid)
                r_branches <= r_branches + STAT_W'(1);
            if (mispredict)
                r_mispred <= r_mispred + STAT_W'(1);
        end
    end

    assign stat_branches = r_branches;
    assign stat_mispred  = r_mispred;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht.
// Driver pushes model expectations; monitor pops and compares.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .clk             (clk),
        .reset           (reset),
        .if_pc           (if_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc),
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
    );

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] cpc;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;

    // Reference model: one slot per index, counter as a plain int 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    // Update seen at the previous clock edge, applied after that edge.
    bit          p_valid = 0;
    bit          p_rn    = 0;
    logic [31:0] p_pc;
    bit          p_taken;
    logic [31:0] p_tgt;
    bit          p_mis;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == (pc >> 6));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_update();
        int i;
        i = midx(p_pc);
        m_br = m_br + 1;
        if (p_mis)
            m_mp = m_mp + 1;
        if (mhit(p_pc)) begin
            if (p_taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = p_tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (p_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = p_pc >> 6;
            m_tgt[i]   = p_tgt;
            m_ctr[i]   = 2;
        end
    endtask

    task automatic step(
        input bit          rn,
        input logic [31:0] pc,
        input bit          uv,
        input logic [31:0] upc,
        input bit          ut,
        input logic [31:0] utg,
        input bit          upt,
        input logic [31:0] uptg
    );
        exp_t e;
        @(posedge clk);
        #1;
        if (p_valid && p_rn)
            model_update();
        reset           = rn;
        if_pc           = pc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utg;
        upd_pred_taken  = upt;
        upd_pred_target = uptg;
        if (!rn)
            model_clear();
        e.hit    = mhit(pc);
        e.taken  = e.hit && (m_ctr[midx(pc)] >= 2);
        e.target = e.taken ? m_tgt[midx(pc)] : pc + 32'd4;
        e.mis    = uv && ((ut != upt) || (ut && (uptg != utg)));
        e.cpc    = uv ? (ut ? utg : upc + 32'd4) : 32'd0;
        e.br     = m_br;
        e.mp     = m_mp;
        exp_q.push_back(e);
        p_valid = uv;
        p_rn    = rn;
        p_pc    = upc;
        p_taken = ut;
        p_tgt   = utg;
        p_mis   = e.mis;
    endtask

    task automatic look(input logic [31:0] pc);
        step(1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(
        input logic [31:0] lpc,
        input logic [31:0] upc,
        input bit          ut,
        input logic [31:0] utg,
        input bit          upt,
        input logic [31:0] uptg
    );
        step(1, lpc, 1, upc, ut, utg, upt, uptg);
    endtask

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h",
                     name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pred_hit",      32'(pred_hit),      32'(e.hit));
            chk("pred_taken",    32'(pred_taken),    32'(e.taken));
            chk("pred_target",   pred_target,        e.target);
            chk("mispredict",    32'(mispredict),    32'(e.mis));
            chk("correct_pc",    correct_pc,         e.cpc);
            chk("stat_branches", stat_branches,      e.br);
            chk("stat_mispred",  stat_mispred,       e.mp);
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] upc;
        logic [31:0] tg;
        bit          ut;
        bit          upt;
        logic [31:0] uptg;
        reset           = 1'b0;
        if_pc           = 32'h40;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
        model_clear();

        step(0, 32'h40, 0, 0, 0, 0, 0, 0);
        look(32'h40);
        upd(32'h40, 32'h40, 1, 32'h100, 0, 32'h0);
        look(32'h40);
        look(32'h80);
        upd(32'h80, 32'h80, 1, 32'h200, 0, 32'h0);
        look(32'h40);
        upd(32'h80, 32'h80, 1, 32'h200, 1, 32'h200);
        upd(32'h80, 32'h80, 1, 32'h200, 1, 32'h200);
        upd(32'h80, 32'h80, 1, 32'h200, 1, 32'h200);
        upd(32'h80, 32'h80, 0, 32'h200, 1, 32'h200);
        look(32'h80);
        upd(32'h80, 32'h80, 0, 32'h200, 1, 32'h200);
        look(32'h80);
        upd(32'h80, 32'h80, 0, 32'h200, 0, 32'h84);
        upd(32'h80, 32'h80, 1, 32'h300, 0, 32'h84);
        look(32'h80);
        upd(32'h3C, 32'h3C, 0, 32'h500, 0, 32'h40);
        look(32'h3C);
        look(32'hFFFF_FFFC);
        upd(32'h81, 32'h82, 1, 32'h340, 1, 32'h300);
        look(32'h83);
        step(0, 32'h80, 1, 32'h80, 1, 32'h400, 0, 0);
        upd(32'h80, 32'h80, 1, 32'h500, 0, 32'h0);
        look(32'h80);

        for (int n = 0; n < 2000; n++) begin
            pc  = ($urandom_range(0, 7) == 0) ? $urandom
                : {26'($urandom_range(0, 3)), 6'($urandom)};
            upc = {26'($urandom_range(0, 3)), 6'($urandom)};
            tg  = $urandom & 32'hFFFF_FFFC;
            ut  = 1'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                upt  = mhit(upc) && (m_ctr[midx(upc)] >= 2);
                uptg = upt ? m_tgt[midx(upc)] : upc + 32'd4;
                if ($urandom_range(0, 1) == 0 && mhit(upc))
                    tg = m_tgt[midx(upc)];
            end else begin
                upt  = 1'($urandom);
                uptg = $urandom;
            end
            step(($urandom_range(0, 199) != 0), pc,
                 1'($urandom), upc, ut, tg, upt, uptg);
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++)
            @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
